// File: rtl/rotate_vram_bridge.sv
// rtl/rotate_vram_bridge.sv - burst-to-single-word bridge between rotate engine and RAM port
//
// Purpose: services 16-word vidin write bursts and 8-word vidout read bursts
// from the scandoubler rotation path, issuing one req/ack RAM transaction per
// word at address {frame,row,col+beat}. Bursts never interleave; contention
// alternates between writer and reader.
//
// Ports:
//   clk_sys, reset_n          system clock, asynchronous active-low reset
//   vidin_req/frame/row/col   write burst request and framebuffer position
//   vidin_d, vidin_ack        write word and its one-cycle consume pulse
//   vidout_req/frame/row/col  read burst request and framebuffer position
//   vidout_d, vidout_ack      read word and its one-cycle valid pulse
//   mem_req, mem_we, mem_addr, mem_wd, mem_rd, mem_ack
//                             single-word req/ack RAM controller port
module rotate_vram_bridge #(
  parameter int WR_BURST_LOG2 = 4,
  parameter int RD_BURST_LOG2 = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        vidin_req,
  input  logic        vidin_frame,
  input  logic [9:0]  vidin_row,
  input  logic [9:0]  vidin_col,
  input  logic [15:0] vidin_d,
  output logic        vidin_ack,
  input  logic        vidout_req,
  input  logic        vidout_frame,
  input  logic [9:0]  vidout_row,
  input  logic [9:0]  vidout_col,
  output logic [15:0] vidout_d,
  output logic        vidout_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [15:0] mem_wd,
  input  logic [15:0] mem_rd,
  input  logic        mem_ack
);

  // Beat counter is shared by both burst kinds, so it is sized for the longer one.
  localparam int BEAT_W = (WR_BURST_LOG2 > RD_BURST_LOG2) ? WR_BURST_LOG2 : RD_BURST_LOG2;
  localparam logic [BEAT_W-1:0] WR_LAST = BEAT_W'((1 << WR_BURST_LOG2) - 1);
  localparam logic [BEAT_W-1:0] RD_LAST = BEAT_W'((1 << RD_BURST_LOG2) - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_FETCH = 3'd1,
    WR_MEM   = 3'd2,
    RD_MEM   = 3'd3,
    RD_NEXT  = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              frame_q;
  logic [9:0]        row_q;
  logic [9:0]        col_q;
  logic [BEAT_W-1:0] beat_q;
  logic              last_grant_rd;   // 0 = last burst was a write
  logic              grant_wr;
  logic              grant_rd;
  logic [9:0]        col_beat;

  // Arbitration: a lone request wins; under contention the side that did
  // not win last time goes next, giving strict alternation.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (vidin_req && vidout_req) begin
      grant_rd = ~last_grant_rd;
      grant_wr = last_grant_rd;
    end else begin
      grant_wr = vidin_req;
      grant_rd = vidout_req;
    end
  end

  // Column wraps modulo 1024; row and frame are never carried into.
  assign col_beat = col_q + 10'(beat_q);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus outputs decoded purely from the state register and
  // latched burst registers, so no input reaches an output combinationally.
  always_comb begin
    state_nxt  = state;
    vidin_ack  = 1'b0;
    vidout_ack = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = 21'd0;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          state_nxt = WR_FETCH;
        end else if (grant_rd) begin
          state_nxt = RD_MEM;
        end
      end
      WR_FETCH: begin
        vidin_ack = 1'b1;
        state_nxt = WR_MEM;
      end
      WR_MEM: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {frame_q, row_q, col_beat};
        if (mem_ack) begin
          state_nxt = (beat_q == WR_LAST) ? GAP : WR_FETCH;
        end
      end
      RD_MEM: begin
        mem_req  = 1'b1;
        mem_addr = {frame_q, row_q, col_beat};
        if (mem_ack) begin
          state_nxt = RD_NEXT;
        end
      end
      RD_NEXT: begin
        vidout_ack = 1'b1;
        state_nxt  = (beat_q == RD_LAST) ? GAP : RD_MEM;
      end
      GAP: begin
        // Dead cycle lets the requester drop req or advance col before the
        // next arbitration.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_q       <= 1'b0;
      row_q         <= 10'd0;
      col_q         <= 10'd0;
      beat_q        <= '0;
      last_grant_rd <= 1'b0;
      mem_wd        <= 16'd0;
      vidout_d      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            frame_q       <= vidin_frame;
            row_q         <= vidin_row;
            col_q         <= vidin_col;
            beat_q        <= '0;
            last_grant_rd <= 1'b0;
          end else if (grant_rd) begin
            frame_q       <= vidout_frame;
            row_q         <= vidout_row;
            col_q         <= vidout_col;
            beat_q        <= '0;
            last_grant_rd <= 1'b1;
          end
        end
        WR_FETCH: begin
          mem_wd <= vidin_d;
        end
        WR_MEM: begin
          if (mem_ack && (beat_q != WR_LAST)) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        RD_MEM: begin
          if (mem_ack) begin
            vidout_d <= mem_rd;
          end
        end
        RD_NEXT: begin
          if (beat_q != RD_LAST) begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_vram_bridge.sv
// tb/tb_rotate_vram_bridge.sv - self-checking bench for rotate_vram_bridge
module tb_rotate_vram_bridge;

  logic        clk_sys;
  logic        reset_n;
  logic        vidin_req;
  logic        vidin_frame;
  logic [9:0]  vidin_row;
  logic [9:0]  vidin_col;
  logic [15:0] vidin_d;
  logic        vidin_ack;
  logic        vidout_req;
  logic        vidout_frame;
  logic [9:0]  vidout_row;
  logic [9:0]  vidout_col;
  logic [15:0] vidout_d;
  logic        vidout_ack;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [15:0] mem_wd;
  logic [15:0] mem_rd;
  logic        mem_ack;

  rotate_vram_bridge #(
    .WR_BURST_LOG2(4),
    .RD_BURST_LOG2(3)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .vidin_req   (vidin_req),
    .vidin_frame (vidin_frame),
    .vidin_row   (vidin_row),
    .vidin_col   (vidin_col),
    .vidin_d     (vidin_d),
    .vidin_ack   (vidin_ack),
    .vidout_req  (vidout_req),
    .vidout_frame(vidout_frame),
    .vidout_row  (vidout_row),
    .vidout_col  (vidout_col),
    .vidout_d    (vidout_d),
    .vidout_ack  (vidout_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_rd      (mem_rd),
    .mem_ack     (mem_ack)
  );

  typedef struct {
    bit          we;
    logic [20:0] addr;
    logic [15:0] wd;
  } txn_t;

  int          tests_run = 0;
  int          fails = 0;
  int          cyc = 0;
  txn_t        exp_q[$];
  logic [15:0] mem_arr[int];
  int          mem_wait = 0;
  bit          mem_rand = 0;
  int          last_mem_ack_cyc = -100;

  int          wr_cmd = 0;
  bit          wr_f = 0;
  int          wr_r = 0;
  int          wr_c = 0;
  int          wr_total = 0;
  int          wr_idx = 0;
  int          wr_acks = 0;
  bit          wr_timing = 0;
  logic [15:0] wr_data_q[$];

  int          rd_cmd = 0;
  bit          rd_f = 0;
  int          rd_r = 0;
  int          rd_c = 0;
  int          rd_total = 0;
  int          rd_idx = 0;
  bit          rd_timing = 0;

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Framebuffer linear map: frame*2^20 + row*2^10 + (col mod 1024).
  function automatic logic [20:0] mk_addr(input bit f, input int r, input int c);
    return 21'((f ? 1048576 : 0) + r * 1024 + (c % 1024));
  endfunction

  // Unwritten locations read back as their own low address bits.
  function automatic logic [15:0] memval(input logic [20:0] a);
    if (mem_arr.exists(int'(a))) return mem_arr[int'(a)];
    return a[15:0];
  endfunction

  // Memory responder: acks after a fixed or random wait, checks every
  // transaction against the expected order, and checks request stability.
  initial begin
    bit   busy;
    int   cnt;
    int   wn;
    txn_t cap;
    txn_t e;
    busy = 0; cnt = 0; wn = 0;
    mem_ack = 1'b0;
    mem_rd  = 16'h0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        mem_ack = 1'b0;
        busy    = 0;
        exp_q.delete();
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        check("mem_req_drop_after_ack", mem_req, 0);
      end else if (mem_req) begin
        if (!busy) begin
          busy    = 1;
          cnt     = 0;
          wn      = mem_rand ? $urandom_range(0, 3) : mem_wait;
          cap.we   = mem_we;
          cap.addr = mem_addr;
          cap.wd   = mem_wd;
        end else begin
          check("mem_req_stable", {mem_we, mem_addr, mem_wd}, {cap.we, cap.addr, cap.wd});
        end
        if (cnt >= wn) begin
          busy = 0;
          mem_ack = 1'b1;
          last_mem_ack_cyc = cyc;
          check("mem_txn_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mem_we", cap.we, e.we);
            check("mem_addr", cap.addr, e.addr);
            if (e.we) check("mem_wd", cap.wd, e.wd);
          end
          if (cap.we) mem_arr[int'(cap.addr)] = cap.wd;
          else mem_rd = memval(cap.addr);
        end else begin
          cnt++;
        end
      end
    end
  end

  // Writer: presents words in order, advances the word one cycle after each
  // ack, moves col by 16 per burst, drops req after the final ack.
  initial begin
    int seen;
    bit adv;
    int start_cyc;
    int prev_ack;
    seen = 0; adv = 0; start_cyc = 0; prev_ack = 0;
    vidin_req = 0; vidin_frame = 0; vidin_row = 0; vidin_col = 0; vidin_d = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        vidin_req = 0;
        adv = 0;
        wr_idx = wr_total;
        seen = wr_cmd;
      end else begin
        if (seen != wr_cmd) begin
          seen = wr_cmd;
          wr_idx = 0;
          wr_acks = 0;
          vidin_frame = wr_f;
          vidin_row = 10'(wr_r);
          vidin_col = 10'(wr_c);
          vidin_d = wr_data_q[0];
          vidin_req = 1;
          start_cyc = cyc;
        end
        if (adv) begin
          adv = 0;
          if (wr_timing && wr_idx == 0) check("wr_mem_req_latency", mem_req, 1);
          wr_idx++;
          if (wr_idx % 16 == 0) vidin_col = vidin_col + 10'd16;
          if (wr_idx >= wr_total) begin
            vidin_req = 0;
            vidin_d = 0;
          end else begin
            vidin_d = wr_data_q[wr_idx];
          end
        end
        if (vidin_ack) begin
          check("wr_ack_expected", wr_acks < wr_total, 1);
          if (wr_timing) begin
            if (wr_acks == 0) check("wr_ack_latency", cyc, start_cyc + 1);
            else if (wr_acks % 16 != 0) check("wr_ack_spacing", cyc - prev_ack, 2);
          end
          prev_ack = cyc;
          wr_acks++;
          adv = 1;
        end
      end
    end
  end

  // Reader: checks each delivered word, advances col by 8 after every 8th ack.
  initial begin
    int          seen;
    int          prev;
    logic [20:0] a;
    seen = 0; prev = 0;
    vidout_req = 0; vidout_frame = 0; vidout_row = 0; vidout_col = 0;
    forever begin
      @(negedge clk_sys);
      if (!reset_n) begin
        vidout_req = 0;
        rd_idx = rd_total;
        seen = rd_cmd;
      end else begin
        if (seen != rd_cmd) begin
          seen = rd_cmd;
          rd_idx = 0;
          vidout_frame = rd_f;
          vidout_row = 10'(rd_r);
          vidout_col = 10'(rd_c);
          vidout_req = 1;
        end
        if (vidout_ack) begin
          check("rd_ack_expected", rd_idx < rd_total, 1);
          a = mk_addr(vidout_frame, int'(vidout_row), int'(vidout_col) + rd_idx % 8);
          check("rd_data", vidout_d, memval(a));
          check("rd_ack_after_mem_ack", cyc, last_mem_ack_cyc + 1);
          if (rd_timing && rd_idx > 0) check("rd_ack_spacing", cyc - prev, (rd_idx % 8 == 0) ? 4 : 2);
          prev = cyc;
          rd_idx++;
          if (rd_idx % 8 == 0) vidout_col = vidout_col + 10'd8;
          if (rd_idx >= rd_total) vidout_req = 0;
        end
      end
    end
  end

  task automatic fill_wdata(input int n, input logic [15:0] base, input bit rnd);
    wr_data_q.delete();
    for (int k = 0; k < n; k++) wr_data_q.push_back(rnd ? 16'($urandom) : base + 16'(k));
  endtask

  task automatic exp_push(input bit we, input bit f, input int r, input int c, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      txn_t t;
      t.we = we;
      t.addr = mk_addr(f, r, c + k);
      t.wd = we ? wr_data_q[k] : 16'h0;
      exp_q.push_back(t);
    end
  endtask

  task automatic issue_write(input bit f, input int r, input int c, input int n);
    wr_f = f; wr_r = r; wr_c = c; wr_total = n;
    wr_cmd++;
  endtask

  task automatic issue_read(input bit f, input int r, input int c, input int n);
    rd_f = f; rd_r = r; rd_c = c; rd_total = n;
    rd_cmd++;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    bit done;
    n = 0; done = 0;
    while (!done && n < budget) begin
      @(negedge clk_sys);
      n++;
      done = (wr_idx >= wr_total) && (rd_idx >= rd_total) && (exp_q.size() == 0) && !mem_ack;
    end
    check(tag, done, 1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic pulse_reset();
    @(posedge clk_sys);
    #1 reset_n = 0;
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1;
  endtask

  initial begin
    bit we;
    bit f;
    int r;
    int c;
    int n;
    bit reached;
    reset_n = 0;
    repeat (3) @(negedge clk_sys);
    check("reset_vidin_ack", vidin_ack, 0);
    check("reset_vidout_ack", vidout_ack, 0);
    check("reset_vidout_d", vidout_d, 0);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_we", mem_we, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_mem_wd", mem_wd, 0);
    @(posedge clk_sys);
    #1 reset_n = 1;

    // Single zero-wait write burst with latency and ack-spacing checks.
    mem_rand = 0; mem_wait = 0; wr_timing = 1;
    @(posedge clk_sys); #1;
    fill_wdata(16, 16'h1000, 0);
    exp_push(1, 1, 5, 32, 0, 16);
    issue_write(1, 5, 32, 16);
    wait_done("single_write_done", 200);
    check("single_write_mem_req_idle", mem_req, 0);
    wr_timing = 0;

    // Read burst with 3 wait cycles per word.
    mem_wait = 3;
    @(posedge clk_sys); #1;
    exp_push(0, 0, 7, 0, 0, 8);
    issue_read(0, 7, 0, 8);
    wait_done("wait_read_done", 200);
    check("wait_read_last_data", vidout_d, 16'h1C07);

    // Contention straight after reset: read, write, read, write.
    pulse_reset();
    mem_rand = 1;
    @(posedge clk_sys); #1;
    fill_wdata(32, 16'h0, 1);
    exp_push(0, 0, 9, 100, 0, 8);
    exp_push(1, 1, 2, 200, 0, 16);
    exp_push(0, 0, 9, 100, 8, 8);
    exp_push(1, 1, 2, 200, 16, 16);
    issue_write(1, 2, 200, 32);
    issue_read(0, 9, 100, 16);
    wait_done("contention_done", 600);

    // Column wrap on read, then on write, then read back the written wrap.
    @(posedge clk_sys); #1;
    exp_push(0, 0, 3, 1020, 0, 8);
    issue_read(0, 3, 1020, 8);
    wait_done("wrap_read_done", 200);
    @(posedge clk_sys); #1;
    fill_wdata(16, 16'h0, 1);
    exp_push(1, 1, 1023, 1016, 0, 16);
    issue_write(1, 1023, 1016, 16);
    wait_done("wrap_write_done", 300);
    @(posedge clk_sys); #1;
    exp_push(0, 1, 1023, 1020, 0, 8);
    issue_read(1, 1023, 1020, 8);
    wait_done("wrap_readback_done", 200);

    // 640-word row as 80 back-to-back zero-wait bursts.
    mem_rand = 0; mem_wait = 0; rd_timing = 1;
    @(posedge clk_sys); #1;
    exp_push(0, 1, 100, 0, 0, 640);
    issue_read(1, 100, 0, 640);
    wait_done("row640_done", 2500);
    rd_timing = 0;

    // Reset while beat 9 of a write is waiting on memory.
    mem_wait = 4;
    @(posedge clk_sys); #1;
    fill_wdata(16, 16'h0, 1);
    exp_push(1, 0, 11, 50, 0, 16);
    issue_write(0, 11, 50, 16);
    reached = 0; n = 0;
    while (!reached && n < 400) begin
      @(negedge clk_sys);
      n++;
      reached = (wr_acks >= 10) && mem_req;
    end
    check("reset_mid_reached_beat9", reached, 1);
    #2 reset_n = 0;
    #1;
    check("reset_mid_mem_req", mem_req, 0);
    check("reset_mid_vidin_ack", vidin_ack, 0);
    check("reset_mid_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk_sys);
    @(posedge clk_sys);
    #1 reset_n = 1;
    mem_wait = 0; wr_timing = 1;
    @(posedge clk_sys); #1;
    fill_wdata(16, 16'h2000, 0);
    exp_push(1, 0, 11, 50, 0, 16);
    issue_write(0, 11, 50, 16);
    wait_done("restart_write_done", 200);
    wr_timing = 0;

    // Randomized single bursts with random memory waits.
    mem_rand = 1;
    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom_range(0, 1));
      f  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 1023);
      c  = $urandom_range(0, 1023);
      @(posedge clk_sys); #1;
      if (we) begin
        fill_wdata(16, 16'h0, 1);
        exp_push(1, f, r, c, 0, 16);
        issue_write(f, r, c, 16);
      end else begin
        exp_push(0, f, r, c, 0, 8);
        issue_read(f, r, c, 8);
      end
      wait_done("random_burst_done", 300);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/rotate_vram_bridge.md
# rotate_vram_bridge

Memory-side responder for the scandoubler rotation path. It services the writer's 16-word `vidin` bursts and the reader's 8-word `vidout` bursts, and turns each one into single-word transactions on a generic req/ack RAM port (SDRAM or SRAM controller front end). Framebuffer addressing is a double-buffered `{frame,row,col}` linear map. The block sits between the rotate engine and the system memory controller, in the `clk_sys` domain.

## Interface
Parameters:
- `WR_BURST_LOG2`, 4, log2 of words per `vidin` burst (16).
- `RD_BURST_LOG2`, 3, log2 of words per `vidout` burst (8).

Ports (one clock; reset is asynchronous and active-low):
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `vidin_req`  in  1  write burst pending; held until the last word is acked.
- `vidin_frame`  in  1  write buffer select.
- `vidin_row`  in  10  write row.
- `vidin_col`  in  10  write burst start column.
- `vidin_d`  in  16  current write word.
- `vidin_ack`  out  1  one-cycle pulse; `vidin_d` is consumed this cycle and the writer advances to the next word.
- `vidout_req`  in  1  read pending; held until the whole row is delivered.
- `vidout_frame`  in  1  read buffer select.
- `vidout_row`  in  10  read row.
- `vidout_col`  in  10  read burst start column.
- `vidout_d`  out  16  read data.
- `vidout_ack`  out  1  one-cycle pulse; `vidout_d` is valid this cycle.
- `mem_req`  out  1  memory transaction request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  21  `{frame,row,col}`.
- `mem_wd`  out  16  write data.
- `mem_rd`  in  16  read data, valid when `mem_ack` is high on a read.
- `mem_ack`  in  1  transaction complete (write accepted or read data valid).

## Operation
- Outputs are registered or decoded from the state register only. There is no combinational path from inputs to outputs.
- State machine: IDLE, WR_FETCH, WR_MEM, RD_MEM, RD_NEXT, GAP.
- IDLE: grant a burst.
  - Only one request high: grant it.
  - Both high: grant the opposite of `last_grant`.
  - Latch frame, row, start column and `last_grant`; clear `beat`.
  - Write granted → WR_FETCH. Read granted → RD_MEM.
- WR_FETCH (1 cycle):
  - `vidin_ack`=1.
  - `mem_wd` ← `vidin_d`.
  - → WR_MEM.
- WR_MEM:
  - `mem_req`=1, `mem_we`=1, address = `{frame,row,col+beat}`.
  - Hold until `mem_ack`.
  - Then: if `beat`==2^WR_BURST_LOG2−1 → GAP; else `beat`++ → WR_FETCH.
- RD_MEM:
  - `mem_req`=1, `mem_we`=0, same address form.
  - On `mem_ack`: `vidout_d` ← `mem_rd` → RD_NEXT.
- RD_NEXT (1 cycle):
  - `vidout_ack`=1.
  - If `beat`==2^RD_BURST_LOG2−1 → GAP; else `beat`++ → RD_MEM.
- GAP (1 cycle): no grant, which gives the requester time to drop `req` or advance `col`. → IDLE.
- A `vidout` row spans many bursts. Each burst re-samples `vidout_col`, which the reader advances by 8 within one cycle of the 8th ack.
- Column arithmetic: `col+beat` is a 10-bit add that wraps modulo 1024 within the same row and frame. Row and frame never increment.

## Timing
- Reset values: state IDLE; `last_grant`=write, so the first contention grants read. All outputs 0: `vidin_ack`, `vidout_ack`, `vidout_d`, `mem_req`, `mem_we`, `mem_addr`, `mem_wd`.
- `mem_req` protocol:
  - `mem_req` rises with `mem_addr`, `mem_we` and `mem_wd` stable.
  - It holds until the cycle `mem_ack` is sampled high, then is low for at least one cycle.
  - `mem_ack` while `mem_req`=0 is ignored.
- Latencies:
  - `vidin_req` seen in IDLE at cycle n → `vidin_ack` at n+1 → `mem_req` at n+2.
  - Minimum `vidin_ack` spacing is 2 cycles, so the writer has one cycle to present the next word.
  - Read: `mem_ack` at cycle m → `vidout_ack` and `vidout_d` valid at m+1.
- Zero-wait memory (`mem_ack` on the first `mem_req` cycle):
  - Write burst: 32 cycles plus 1 GAP.
  - Read burst: 16 cycles plus 1 GAP.
- Request withdrawn mid-burst (protocol violation): the bridge completes the burst anyway, writing the held `vidin_d` or emitting the remaining read acks.
- `reset_n` low mid-transaction: all outputs clear immediately (asynchronous) and the partial burst is abandoned. The requester restarts after reset.
- Requests arriving during a burst or GAP wait in IDLE arbitration. There is no pre-emption.

## Test plan
- Single write burst: frame=1, row=5, col=32, `vidin_d`=0x1000+k on each ack, zero-wait memory → 16 `vidin_ack` pulses 2 cycles apart; memory writes to addr `{1,5,32..47}` with data 0x1000..0x100F; GAP, then IDLE; `mem_req` low.
- Read burst with memory wait of 3 cycles per word: row=7, col=0, `mem_rd`=addr[15:0] → 8 `vidout_ack` pulses, each one cycle after `mem_ack`, data 0x1C00..0x1C07; `mem_req` held stable through each wait.
- Both requests asserted together after reset → read granted first, then write, then read, strictly alternating while both are held; no burst is interleaved with another.
- Column wrap: read col=1020 → addresses col 1020..1023 then 0..3, row unchanged.
- Multi-burst row: `vidout_req` held, reader advances col by 8 after each 8th ack, 640 words → 80 bursts, each separated by exactly one GAP cycle, contiguous addresses 0..639.
- `reset_n` asserted during write beat 9 with `mem_req` high → `mem_req`, `vidin_ack` and `mem_addr` go to 0 asynchronously; after release, state is IDLE and a new `vidin_req` restarts at beat 0.
